// File: rtl/gray_seq_monitor_if.sv
// Gray monitor bus: sample inputs from the counter stage plus monitor status outputs.
interface gray_seq_monitor_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
);
    logic              In_valid;
    logic [WIDTH-1:0]  Gray_in;
    logic              Overflow_in;
    logic              Clr_err;
    logic [WIDTH-1:0]  Bin_out;
    logic              Bin_valid;
    logic [WRAP_W-1:0] Wrap_count;
    logic              Locked;
    logic              Err;
    logic [1:0]        Err_code;

    // Driver side (counter stage / software)
    modport master (
        output In_valid, Gray_in, Overflow_in, Clr_err,
        input  Bin_out, Bin_valid, Wrap_count, Locked, Err, Err_code
    );

    // Monitor side
    modport slave (
        input  In_valid, Gray_in, Overflow_in, Clr_err,
        output Bin_out, Bin_valid, Wrap_count, Locked, Err, Err_code
    );
endinterface

// File: rtl/gray_seq_monitor.sv
// Gray-code sequence monitor: converts sampled Gray values to binary, checks for
// legal single-step forward advance, counts wraps and latches a sticky error code.
// Optional stall limit enabled by defining GRAY_SEQ_MONITOR_STALL_LIMIT_EN.
// Err_code: 01 multi-bit jump, 10 backward step, 11 overflow mismatch / stall limit.
module gray_seq_monitor #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned WRAP_W    = 8,
    parameter int unsigned STALL_MAX = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    gray_seq_monitor_if.slave   bus
);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] LOCKED   = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_JUMP = 2'b01;
    localparam logic [1:0] CODE_BACK = 2'b10;
    localparam logic [1:0] CODE_OVF  = 2'b11;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [1:0]        state_q,     state_d;
    logic [WIDTH-1:0]  last_gray_q, last_gray_d;
    logic              last_ovf_q,  last_ovf_d;
    logic [WIDTH-1:0]  bin_q,       bin_d;
    logic              bin_valid_q, bin_valid_d;
    logic [WRAP_W-1:0] wrap_q,      wrap_d;
    logic              locked_q,    locked_d;
    logic              err_q,       err_d;
    logic [1:0]        code_q,      code_d;

`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stall_err;
`else
    localparam int unsigned unused_stall_max = STALL_MAX;
`endif

    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] last_bin;
    logic [WIDTH-1:0] diff;
    logic             is_stall;
    logic             is_single;
    logic             is_wrap;
    logic             is_fwd;
    logic             ovf_rise;
    logic             ovf_fall;
    logic             upstream_rst;
    logic             jump_err;
    logic             back_err;
    logic             ovf_err;

    // Classify the incoming sample against the last accepted one
    always_comb begin
        gray_bin     = gray2bin(bus.Gray_in);
        last_bin     = gray2bin(last_gray_q);
        diff         = bus.Gray_in ^ last_gray_q;
        is_stall     = (diff == '0);
        is_single    = !is_stall && ((diff & (diff - WIDTH'(1))) == '0);
        is_wrap      = is_single && (last_bin == '1) && (gray_bin == '0);
        is_fwd       = is_single && !is_wrap && (gray_bin == last_bin + WIDTH'(1));
        ovf_rise     = bus.Overflow_in && !last_ovf_q;
        ovf_fall     = !bus.Overflow_in && last_ovf_q;
        // Overflow dropping together with Gray=0 is an upstream counter reset
        upstream_rst = ovf_fall && (bus.Gray_in == '0);
        jump_err     = !upstream_rst && (ovf_fall || (!is_stall && !is_single));
        back_err     = !upstream_rst && is_single && !is_fwd && !is_wrap;
        ovf_err      = ovf_rise && !is_wrap;
    end

`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
    // Stall limit reached on this sample
    always_comb begin
        stall_err = is_stall && (stall_q == STALL_W'(STALL_MAX - 1));
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        last_gray_d = last_gray_q;
        last_ovf_d  = last_ovf_q;
        bin_d       = bin_q;
        bin_valid_d = 1'b0;
        wrap_d      = wrap_q;
        err_d       = err_q;
        code_d      = code_q;
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
        stall_d     = stall_q;
`endif

        if (bus.Clr_err) begin
            state_d = UNLOCKED;
            err_d   = 1'b0;
            code_d  = CODE_NONE;
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
            stall_d = '0;
`endif
        end else if (bus.In_valid) begin
            case (state_q)
                UNLOCKED: begin
                    last_gray_d = bus.Gray_in;
                    last_ovf_d  = bus.Overflow_in;
                    bin_d       = gray_bin;
                    bin_valid_d = 1'b1;
                    state_d     = LOCKED;
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
                    stall_d     = '0;
`endif
                end
                LOCKED: begin
                    if (jump_err) begin
                        err_d   = 1'b1;
                        code_d  = CODE_JUMP;
                        state_d = ERROR;
                    end else if (back_err) begin
                        err_d   = 1'b1;
                        code_d  = CODE_BACK;
                        state_d = ERROR;
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
                    end else if (ovf_err || stall_err) begin
`else
                    end else if (ovf_err) begin
`endif
                        err_d   = 1'b1;
                        code_d  = CODE_OVF;
                        state_d = ERROR;
                    end else begin
                        last_gray_d = bus.Gray_in;
                        last_ovf_d  = bus.Overflow_in;
                        bin_d       = gray_bin;
                        bin_valid_d = 1'b1;
                        if (is_wrap && (wrap_q != '1)) begin
                            wrap_d = wrap_q + WRAP_W'(1);
                        end
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
                        stall_d = is_stall ? stall_q + STALL_W'(1) : '0;
`endif
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= UNLOCKED;
            last_gray_q <= '0;
            last_ovf_q  <= 1'b0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            wrap_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= CODE_NONE;
        end else begin
            state_q     <= state_d;
            last_gray_q <= last_gray_d;
            last_ovf_q  <= last_ovf_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            wrap_q      <= wrap_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
    // Consecutive stall sample counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign bus.Bin_out    = bin_q;
    assign bus.Bin_valid  = bin_valid_q;
    assign bus.Wrap_count = wrap_q;
    assign bus.Locked     = locked_q;
    assign bus.Err        = err_q;
    assign bus.Err_code   = code_q;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Scoreboard bench for gray_seq_monitor: stimulus pushes expected samples,
// a negedge monitor pops and compares on every Bin_valid pulse.
module tb_gray_seq_monitor;

    typedef struct packed {
        logic [2:0] bin;
        logic [7:0] wrap;
    } exp_t;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;
    int   exp_wrap;
    exp_t sb_q[$];

    logic [2:0] g_seq [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    logic [2:0] b_seq [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    gray_seq_monitor_if #(.WIDTH(3), .WRAP_W(8)) bus ();

    gray_seq_monitor #(.WIDTH(3), .WRAP_W(8), .STALL_MAX(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] bin);
        exp_t e;
        e.bin  = bin;
        e.wrap = 8'(exp_wrap);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs; returns #1 after the consuming edge
    task automatic step(input logic v, input logic [2:0] g, input logic o, input logic c);
        bus.In_valid    = v;
        bus.Gray_in     = g;
        bus.Overflow_in = o;
        bus.Clr_err     = c;
        @(posedge Clk);
        #1;
        bus.In_valid = 1'b0;
        bus.Clr_err  = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n === 1'b1 && bus.Bin_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: Bin_out=%0d Wrap_count=%0d with no expected sample",
                             bus.Bin_out, bus.Wrap_count);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.Bin_out !== e.bin || bus.Wrap_count !== e.wrap) begin
                        errors++;
                        $display("FAIL sb_sample: Bin_out=%0d Wrap_count=%0d, expected %0d %0d",
                                 bus.Bin_out, bus.Wrap_count, e.bin, e.wrap);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        exp_wrap = 0;
        bus.In_valid    = 1'b0;
        bus.Gray_in     = 3'd0;
        bus.Overflow_in = 1'b0;
        bus.Clr_err     = 1'b0;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_bin",    int'(bus.Bin_out),    0);
        chk("rst_valid",  int'(bus.Bin_valid),  0);
        chk("rst_wrap",   int'(bus.Wrap_count), 0);
        chk("rst_locked", int'(bus.Locked),     0);
        chk("rst_err",    int'(bus.Err),        0);
        chk("rst_code",   int'(bus.Err_code),   0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Full forward sequence with overflow rising on the wrap
        for (int i = 0; i < 9; i++) begin
            if (i == 8) exp_wrap = 1;
            push(b_seq[i]);
            step(1'b1, g_seq[i], (i == 8), 1'b0);
            if (i == 0) chk("lock_first", int'(bus.Locked), 1);
        end
        chk("seq_wrap", int'(bus.Wrap_count), 1);
        chk("seq_err",  int'(bus.Err),        0);

        // Backward step 3 -> 1
        push(3'd1); step(1'b1, 3'd1, 1'b1, 1'b0);
        push(3'd2); step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd1, 1'b1, 1'b0);
        chk("back_err",    int'(bus.Err),       1);
        chk("back_code",   int'(bus.Err_code),  2);
        chk("back_bin",    int'(bus.Bin_out),   2);
        chk("back_valid",  int'(bus.Bin_valid), 0);
        chk("back_locked", int'(bus.Locked),    0);
        step(1'b1, 3'd2, 1'b1, 1'b0);
        chk("error_hold_err",  int'(bus.Err),      1);
        chk("error_hold_code", int'(bus.Err_code), 2);
        chk("error_hold_bin",  int'(bus.Bin_out),  2);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        chk("clr_err",    int'(bus.Err),        0);
        chk("clr_code",   int'(bus.Err_code),   0);
        chk("clr_locked", int'(bus.Locked),     0);
        chk("clr_wrap",   int'(bus.Wrap_count), 1);

        // Multi-bit jump 1 -> 6, then clear racing a sample
        push(3'd1); step(1'b1, 3'd1, 1'b1, 1'b0);
        chk("relock", int'(bus.Locked), 1);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        chk("jump_code", int'(bus.Err_code), 1);
        chk("jump_bin",  int'(bus.Bin_out),  1);
        step(1'b1, 3'd5, 1'b1, 1'b1);
        chk("clr_wins_err",    int'(bus.Err),       0);
        chk("clr_wins_locked", int'(bus.Locked),    0);
        chk("clr_wins_valid",  int'(bus.Bin_valid), 0);
        push(3'd6); step(1'b1, 3'd5, 1'b1, 1'b0);
        chk("after_clr_bin",    int'(bus.Bin_out), 6);
        chk("after_clr_locked", int'(bus.Locked),  1);

        // Upstream reset (overflow falls with Gray 0), then overflow rises on 2 -> 6
        push(3'd0); step(1'b1, 3'd0, 1'b0, 1'b0);
        chk("upstream_rst_err", int'(bus.Err), 0);
        push(3'd1); step(1'b1, 3'd1, 1'b0, 1'b0);
        push(3'd2); step(1'b1, 3'd3, 1'b0, 1'b0);
        push(3'd3); step(1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        chk("ovf_code", int'(bus.Err_code), 3);
        chk("ovf_bin",  int'(bus.Bin_out),  3);
        step(1'b0, 3'd0, 1'b0, 1'b1);

        // 300 full cycles: wrap counter saturates
        push(3'd0); step(1'b1, 3'd0, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            for (int j = 1; j < 9; j++) begin
                if (j == 8 && exp_wrap < 255) exp_wrap++;
                push(b_seq[j]);
                step(1'b1, g_seq[j], 1'b0, 1'b0);
            end
        end
        chk("sat_wrap", int'(bus.Wrap_count), 255);
        chk("sat_err",  int'(bus.Err),        0);

        // Hold Gray 7 for four stall samples
        for (int j = 1; j < 6; j++) begin
            push(b_seq[j]);
            step(1'b1, g_seq[j], 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
            if (k < 3) push(3'd5);
`else
            push(3'd5);
`endif
            step(1'b1, 3'd7, 1'b0, 1'b0);
        end
`ifdef GRAY_SEQ_MONITOR_STALL_LIMIT_EN
        chk("stall_err",  int'(bus.Err),      1);
        chk("stall_code", int'(bus.Err_code), 3);
        step(1'b0, 3'd0, 1'b0, 1'b1);
`else
        chk("stall_err",    int'(bus.Err),    0);
        chk("stall_locked", int'(bus.Locked), 1);
`endif

        // Asynchronous reset between clock edges
        push(3'd5); step(1'b1, 3'd7, 1'b0, 1'b0);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_bin",    int'(bus.Bin_out),    0);
        chk("async_valid",  int'(bus.Bin_valid),  0);
        chk("async_wrap",   int'(bus.Wrap_count), 0);
        chk("async_locked", int'(bus.Locked),     0);
        chk("async_err",    int'(bus.Err),        0);
        chk("async_code",   int'(bus.Err_code),   0);
        #3 Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
